maj_digit_serial_adder: RTL and testbench

- Multi-cycle adder for WIDTH-bit operands that consumes 2 bits per cycle.
- Each cycle evaluates one 2-bit majority-carry slice (sum = parity, carry = MAJ) and carries the result into the next cycle through a carry register.
- Sits downstream of the combinational 2-bit majority adder benchmarks. Reuses the same slice function as a sequential datapath for wide operands.
- Valid/ready handshakes on input and output.

---
 rtl/maj_digit_serial_adder.sv | 79 +++++++
 tb/tb_maj_digit_serial_adder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/maj_digit_serial_adder.sv
// maj_digit_serial_adder: 2-bit-per-cycle majority-carry serial adder; define MAJ_SERIAL_ADD_OVF_EN for the ovf output
module maj_digit_serial_adder #(
  parameter int WIDTH = 8,
  localparam int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef MAJ_SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
    $error("maj_digit_serial_adder: WIDTH must be even and >= 2");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic carry, s0, c1, s1, c2;
  logic [CNT_W-1:0] cnt;
  assign s0 = a_sr[0] ^ b_sr[0] ^ carry;
  assign c1 = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign s1 = a_sr[1] ^ b_sr[1] ^ c1;
  assign c2 = (a_sr[1] & b_sr[1]) | (a_sr[1] & c1) | (b_sr[1] & c1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
`ifdef MAJ_SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a_in;
          b_sr  <= b_in;
          carry <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          // new digit enters at the top so the first digit lands at bit 0
          sum   <= WIDTH'({s1, s0, sum} >> 2);
          a_sr  <= a_sr >> 2;
          b_sr  <= b_sr >> 2;
          carry <= c2;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH / 2 - 1)) begin
            cout  <= c2;
`ifdef MAJ_SERIAL_ADD_OVF_EN
            ovf   <= c1 ^ c2;
`endif
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maj_digit_serial_adder.sv
// tb_maj_digit_serial_adder: directed checks of the serial adder (WIDTH=8)
module tb_maj_digit_serial_adder;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy, ovf;
  logic [7:0] a_in, b_in, sum;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  maj_digit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
`ifdef MAJ_SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef MAJ_SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a_in = 8'hA5; b_in = 8'hC3; cin = 1'b1;
  endtask
  // counts edges including the accepting one until out_valid is seen
  task automatic wait_done(input logic [7:0] es, input logic ec, input logic eo);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, 5);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
`ifdef MAJ_SERIAL_ADD_OVF_EN
    check("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) check("ovf_unused", 32'(ovf), 0);
`endif
  endtask
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo);
    accept(a, b, c);
    wait_done(es, ec, eo);
    @(posedge clk);
    #1 check("idle_in_ready", 32'(in_ready), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_sum_hold", 32'(sum), 32'(es));
  endtask
  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    rst = 1'b0;
    do_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // backpressure: hold the result while offering new operands
    out_ready = 1'b0;
    accept(8'h5A, 8'h3C, 1'b0);
    wait_done(8'h96, 1'b0, 1'b1);
    a_in = 8'h11; b_in = 8'h22; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("bp_out_valid", 32'(out_valid), 1);
      check("bp_sum", 32'(sum), 32'h96);
      check("bp_busy", 32'(busy), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_ready", 32'(in_ready), 1);
    check("bp_release_sum", 32'(sum), 32'h96);
    @(posedge clk);
    #1 check("bp_no_late_accept", 32'(busy), 0);
    // reset during the second RUN cycle
    accept(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_sum", 32'(sum), 0);
    check("midrst_cout", 32'(cout), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
